// File: rtl/float_pkg.sv
// Shared definitions for the sequential single-precision float datapath
// (adder state encoding, IEEE-754 field constants and small helpers).
package float_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SPECIAL,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_PACK,
    ST_OUTPUT
  } float_add_state_t;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MIN  = -126;
  localparam int EXP_MAX  = 127;

  localparam logic [31:0] QNAN    = 32'hFFC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int EXP_W  = 10;  // signed unbiased exponent
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;  // hidden + fraction + guard/round/sticky

  typedef logic signed [EXP_W-1:0] exp_t;
  typedef logic [MANT_W-1:0]       mant_t;

  function automatic exp_t unpack_exp(input logic [7:0] f);
    return (f == 8'd0) ? exp_t'(EXP_MIN) : exp_t'({2'b00, f}) - exp_t'(EXP_BIAS);
  endfunction

  // Right shift that folds every shifted-out bit into the sticky LSB.
  function automatic mant_t shr_sticky(input mant_t m, input logic [EXP_W-1:0] n);
    mant_t r;
    logic  st;
    if (n > 10'd26) begin
      r = {{(MANT_W-1){1'b0}}, |m};
    end else begin
      r    = m >> n;
      st   = |(m & ~(mant_t'('1) << n));
      r[0] = r[0] | st;
    end
    return r;
  endfunction

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even on a 27-bit {hidden, fraction, G, R, S} mantissa;
// carry flags a rounding overflow out of the 24-bit significand.
module float_round_rne
  import float_pkg::*;
(
  input  logic [MANT_W-1:0] m_in,
  output logic [23:0]       m_out,
  output logic              carry
);

  logic        inc;
  logic [24:0] sum;

  always_comb begin
    inc   = m_in[2] & (m_in[1] | m_in[0] | m_in[3]);
    sum   = {1'b0, m_in[26:3]} + {24'b0, inc};
    m_out = sum[23:0];
    carry = sum[24];
  end

endmodule

// File: rtl/float_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder with valid/ready on both sides.
// Define FLOAT_ADD_FTZ_EN to flush denormal inputs and results to signed zero.
module float_add_seq
  import float_pkg::*;
#(
  parameter int ALIGN_BARREL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic        busy
);

  float_add_state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic        as_q, as_d, bs_q, bs_d, zs_q, zs_d;
  exp_t        ae_q, ae_d, be_q, be_d, ze_q, ze_d;
  mant_t       am_q, am_d, bm_q, bm_d;
  logic [27:0] sum_q, sum_d;
  logic [23:0] zm_q, zm_d;

  exp_t        diff;
  logic [9:0]  mag, step, room, nstep;
  logic [4:0]  lz;
  logic [23:0] rnd_m;
  logic        rnd_c;
  exp_t        pack_e;
  logic        a_nan, b_nan, a_inf, b_inf;

  float_round_rne u_round (
    .m_in  (sum_q[26:0]),
    .m_out (rnd_m),
    .carry (rnd_c)
  );

  always_comb begin
    diff = ae_q - be_q;
    mag  = diff[9] ? 10'(-diff) : 10'(diff);
    step = (ALIGN_BARREL != 0 || mag > 10'd26) ? mag : 10'd1;
    lz   = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum_q[i]) lz = 5'(26 - i);
    end
    room  = 10'(ze_q - exp_t'(EXP_MIN));
    nstep = (ALIGN_BARREL != 0) ? ((10'(lz) < room) ? 10'(lz) : room) : 10'd1;
    a_nan = (&a_q[30:23]) & (|a_q[22:0]);
    b_nan = (&b_q[30:23]) & (|b_q[22:0]);
    a_inf = (&a_q[30:23]) & ~(|a_q[22:0]);
    b_inf = (&b_q[30:23]) & ~(|b_q[22:0]);
  end

  always_comb begin
    state_d = state_q;
    a_d = a_q;  b_d = b_q;  z_d = z_q;
    as_d = as_q; bs_d = bs_q; zs_d = zs_q;
    ae_d = ae_q; be_d = be_q; ze_d = ze_q;
    am_d = am_q; bm_d = bm_q;
    sum_d = sum_q;
    zm_d = zm_q;
    pack_e = ze_q + exp_t'(EXP_BIAS);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        as_d = a_q[31];
        bs_d = b_q[31];
        ae_d = unpack_exp(a_q[30:23]);
        be_d = unpack_exp(b_q[30:23]);
        am_d = {|a_q[30:23], a_q[22:0], 3'b000};
        bm_d = {|b_q[30:23], b_q[22:0], 3'b000};
`ifdef FLOAT_ADD_FTZ_EN
        if (a_q[30:23] == 8'd0) am_d = '0;
        if (b_q[30:23] == 8'd0) bm_d = '0;
`endif
        state_d = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        // A zero mantissa here means a true zero (or a flushed denormal).
        state_d = ST_OUTPUT;
        if (a_nan || b_nan)                       z_d = QNAN;
        else if (a_inf && b_inf && (as_q != bs_q)) z_d = QNAN;
        else if (a_inf)                           z_d = a_q;
        else if (b_inf)                           z_d = b_q;
        else if (am_q == '0 && bm_q == '0)        z_d = {as_q & bs_q, 31'b0};
        else if (am_q == '0)                      z_d = b_q;
        else if (bm_q == '0)                      z_d = a_q;
        else                                      state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (diff == '0) begin
          state_d = ST_ADD;
        end else if (!diff[9]) begin
          bm_d = shr_sticky(bm_q, step);
          be_d = be_q + exp_t'(step);
        end else begin
          am_d = shr_sticky(am_q, step);
          ae_d = ae_q + exp_t'(step);
        end
      end
      ST_ADD: begin
        ze_d = ae_q;
        if (as_q == bs_q) begin
          sum_d = {1'b0, am_q} + {1'b0, bm_q};
          zs_d  = as_q;
        end else if (am_q >= bm_q) begin
          sum_d = {1'b0, am_q} - {1'b0, bm_q};
          zs_d  = as_q;
        end else begin
          sum_d = {1'b0, bm_q} - {1'b0, am_q};
          zs_d  = bs_q;
        end
        if (sum_d == '0) begin
          z_d = '0;
          state_d = ST_OUTPUT;
        end else begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (sum_q[27]) begin
          sum_d = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          ze_d  = ze_q + exp_t'(1);
        end else if (!sum_q[26] && ze_q > exp_t'(EXP_MIN)) begin
          sum_d = sum_q << nstep;
          ze_d  = ze_q - exp_t'(nstep);
`ifdef FLOAT_ADD_FTZ_EN
        end else if (!sum_q[26]) begin
          z_d = {zs_q, 31'b0};
          state_d = ST_OUTPUT;
`endif
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (rnd_c) begin
          zm_d = {1'b1, rnd_m[23:1]};
          ze_d = ze_q + exp_t'(1);
        end else begin
          zm_d = rnd_m;
        end
        state_d = ST_PACK;
      end
      ST_PACK: begin
        if (ze_q > exp_t'(EXP_MAX)) begin
          z_d = {zs_q, POS_INF[30:0]};
        end else if (ze_q == exp_t'(EXP_MIN) && !zm_q[23]) begin
`ifdef FLOAT_ADD_FTZ_EN
          z_d = {zs_q, 31'b0};
`else
          z_d = {zs_q, 8'h00, zm_q[22:0]};
`endif
        end else begin
          z_d = {zs_q, pack_e[7:0], zm_q[22:0]};
        end
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q <= '0;  b_q <= '0;  z_q <= '0;
      as_q <= 1'b0; bs_q <= 1'b0; zs_q <= 1'b0;
      ae_q <= '0; be_q <= '0; ze_q <= '0;
      am_q <= '0; bm_q <= '0;
      sum_q <= '0;
      zm_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;  b_q <= b_d;  z_q <= z_d;
      as_q <= as_d; bs_q <= bs_d; zs_q <= zs_d;
      ae_q <= ae_d; be_q <= be_d; ze_q <= ze_d;
      am_q <= am_d; bm_q <= bm_d;
      sum_q <= sum_d;
      zm_q <= zm_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_OUTPUT);
  assign z         = z_q;

endmodule

// File: tb/tb_float_add_seq.sv
// Self-checking bench for float_add_seq: vector table through a scoreboard
// queue, plus backpressure-hold and reset-mid-ALIGN sequences.
module tb_float_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];
  logic [31:0] exp_q[$];

`ifdef FLOAT_ADD_FTZ_EN
  localparam logic [31:0] DEN_SUM  = 32'h0000_0000;
  localparam logic [31:0] DEN_DIFF = 32'h0080_0000;
`else
  localparam logic [31:0] DEN_SUM  = 32'h0000_0002;
  localparam logic [31:0] DEN_DIFF = 32'h007F_FFFF;
`endif

  float_add_seq #(.ALIGN_BARREL(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input string name, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] ve);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    exp_q.push_back(ve);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic receive(input string name, input int hold);
    int n = 0;
    logic [31:0] e, z0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_z"}, z, e);
    chk({name, "_in_ready_in_output"}, 32'(in_ready), 32'd0);
    z0 = z;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("%s_hold%0d_valid", name, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s_hold%0d_z", name, i), z, z0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_valid_cleared"}, 32'(out_valid), 32'd0);
    chk({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
    vecs[1]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
    vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[3]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'hFFC0_0000};
    vecs[4]  = '{32'h7F80_0000, 32'hFF80_0000, 32'hFFC0_0000};
    vecs[5]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
    vecs[6]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
    vecs[7]  = '{32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001};
    vecs[8]  = '{32'h0000_0001, 32'h0000_0001, DEN_SUM};
    vecs[9]  = '{32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000};
    vecs[10] = '{32'h40A0_0000, 32'hC040_0000, 32'h4000_0000};
    vecs[11] = '{32'h4000_0000, 32'hBFC0_0000, 32'h3F00_0000};
    vecs[12] = '{32'h0000_0000, 32'hC040_0000, 32'hC040_0000};
    vecs[13] = '{32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000};
    vecs[14] = '{32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000};
    vecs[15] = '{32'h0080_0000, 32'h8000_0001, DEN_DIFF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_z", z, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      send($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
      receive($sformatf("vec%0d", i), (i == 0) ? 5 : int'($urandom_range(0, 2)));
    end

    // Reset while the 24-step alignment is in progress.
    send("abort", 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_z", z, 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);

    send("post_abort", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    receive("post_abort", 1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
